// File: rtl/dot_matrix_scanner_pkg.sv
// rtl/dot_matrix_scanner_pkg.sv - shared constants, phase type and row-pin helpers
// Purpose: matrix geometry and row polarity helpers. The pattern generator
//          uses the same geometry.
// Ports:   none (package)
package dot_matrix_scanner_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ROW_W = 3;

  typedef enum logic [1:0] {
    PH_BLANK = 2'd0,
    PH_ON    = 2'd1,
    PH_OFF   = 2'd2
  } phase_e;

  // All row pins in their inactive state.
  function automatic logic [ROWS-1:0] row_off(input bit active_low);
    return active_low ? {ROWS{1'b1}} : {ROWS{1'b0}};
  endfunction

  // Only the pin for 'row' is active. The polarity follows active_low.
  function automatic logic [ROWS-1:0] row_on(input logic [ROW_W-1:0] row, input bit active_low);
    logic [ROWS-1:0] onehot;
    onehot = ROWS'(1) << row;
    return active_low ? ~onehot : onehot;
  endfunction

endpackage

// File: rtl/dot_matrix_scanner_scan_timer.sv
// rtl/dot_matrix_scanner_scan_timer.sv - row period counter, row sequencer and phase decode
// Purpose: produces the in-row cycle count, the row index, the frame pulse and
//          the BLANK/ON/OFF phase of the current cycle.
// Ports:   i_clock, i_reset_n (sync, active-low)
//          i_bright      : brightness latched for the current row
//          o_row_count   : row currently requested from the generator
//          o_frame_done  : 1-cycle pulse on the row 7->0 wrap
//          o_capture     : high on the last blank cycle (the capture edge follows it)
//          o_phase       : phase decode of the current cycle
module dot_matrix_scanner_scan_timer
  import dot_matrix_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 2500,
  parameter int BLANK_CYCLES = 4
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [2:0]       i_bright,
  output logic [ROW_W-1:0] o_row_count,
  output logic             o_frame_done,
  output logic             o_capture,
  output phase_e           o_phase
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SLICE = (SCAN_DIV - BLANK_CYCLES) / 8;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CAP_AT    = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [ROW_W-1:0] r_row;
  logic             r_frame_done;
  logic             w_wrap;
  logic [CNT_W:0]   w_on_end;

  assign w_wrap = (r_cnt == CNT_LAST);

  // The ON window ends at BLANK + SLICE*(bright+1). One extra bit holds the
  // full-row case, where the end equals SCAN_DIV.
  assign w_on_end = (CNT_W+1)'(BLANK_CYCLES)
                  + (CNT_W+1)'(SLICE) * (CNT_W+1)'(i_bright)
                  + (CNT_W+1)'(SLICE);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_cnt        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt        <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      if (w_wrap) r_row <= r_row + ROW_W'(1);
      r_frame_done <= w_wrap && (r_row == ROW_W'(ROWS - 1));
    end
  end

  always_comb begin
    o_phase = PH_OFF;
    if (r_cnt < BLANK_END)              o_phase = PH_BLANK;
    else if ({1'b0, r_cnt} < w_on_end)  o_phase = PH_ON;
  end

  assign o_capture    = (r_cnt == CAP_AT);
  assign o_row_count  = r_row;
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/dot_matrix_scanner.sv
// rtl/dot_matrix_scanner.sv - 8x8 LED matrix row-scan driver with ghost blanking and PWM
// Purpose: steps through rows 0..7 and latches the generator's column pattern
//          once per row. It drives the row and column pins from registers.
// Ports:   i_clock, i_reset_n (sync, active-low)
//          i_dot_col[7:0]     : column pattern for o_row_count (1 = LED on)
//          i_brightness[2:0]  : PWM level, 0 = 1/8 on-time, 7 = full
//          i_display_en       : 0 blanks the outputs; scanning continues
//          o_row_count[2:0]   : row requested from the generator
//          o_dot_row[7:0]     : row select pins (polarity per ROW_ACTIVE_LOW)
//          o_dot_col_out[7:0] : column pins, active-high
//          o_frame_done       : 1-cycle pulse on the 7->0 row wrap
module dot_matrix_scanner
  import dot_matrix_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 2500,
  parameter int BLANK_CYCLES   = 4,
  parameter int ROW_ACTIVE_LOW = 1
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [COLS-1:0]  i_dot_col,
  input  logic [2:0]       i_brightness,
  input  logic             i_display_en,
  output logic [ROW_W-1:0] o_row_count,
  output logic [ROWS-1:0]  o_dot_row,
  output logic [COLS-1:0]  o_dot_col_out,
  output logic             o_frame_done
);

  localparam bit ACTIVE_LOW = (ROW_ACTIVE_LOW != 0);

  logic [COLS-1:0]  r_col;
  logic [2:0]       r_bright;
  logic [ROWS-1:0]  r_dot_row;
  logic [COLS-1:0]  r_dot_col_out;
  logic [ROW_W-1:0] w_row;
  logic             w_capture;
  phase_e           w_phase;

  dot_matrix_scanner_scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_timer (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_bright     (r_bright),
    .o_row_count  (w_row),
    .o_frame_done (o_frame_done),
    .o_capture    (w_capture),
    .o_phase      (w_phase)
  );

  // Pattern and brightness are sampled once, at the end of the blank window.
  // This gives the generator BLANK_CYCLES clocks to settle after a row change.
  // Mid-row input changes therefore only show on the next row.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_col         <= '0;
      r_bright      <= '0;
      r_dot_row     <= row_off(ACTIVE_LOW);
      r_dot_col_out <= '0;
    end else begin
      if (w_capture) begin
        r_col    <= i_dot_col;
        r_bright <= i_brightness;
      end
      if ((w_phase == PH_ON) && i_display_en) begin
        r_dot_row     <= row_on(w_row, ACTIVE_LOW);
        r_dot_col_out <= r_col;
      end else begin
        r_dot_row     <= row_off(ACTIVE_LOW);
        r_dot_col_out <= '0;
      end
    end
  end

  assign o_row_count   = w_row;
  assign o_dot_row     = r_dot_row;
  assign o_dot_col_out = r_dot_col_out;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// tb/tb_dot_matrix_scanner.sv - directed self-checking bench for dot_matrix_scanner
module tb_dot_matrix_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       display_en;
  logic [2:0] brightness;
  logic [7:0] dot_col;
  logic [2:0] row_count;
  logic [7:0] dot_row;
  logic [7:0] dot_col_out;
  logic       frame_done;

  logic       ovr;
  logic [7:0] ovr_val;

  int k;       // posedges since the last reset edge
  int n_vec;
  int n_err;

  always #5 clk = ~clk;

  // The pattern generator returns 0x11*(row+1). An override can replace it.
  always_comb dot_col = ovr ? ovr_val : 8'(8'h11 * (int'(row_count) + 1));

  dot_matrix_scanner #(
    .SCAN_DIV       (20),
    .BLANK_CYCLES   (4),
    .ROW_ACTIVE_LOW (1)
  ) dut (
    .i_clock       (clk),
    .i_reset_n     (reset_n),
    .i_dot_col     (dot_col),
    .i_brightness  (brightness),
    .i_display_en  (display_en),
    .o_row_count   (row_count),
    .o_dot_row     (dot_row),
    .o_dot_col_out (dot_col_out),
    .o_frame_done  (frame_done)
  );

  typedef struct {
    int         k;
    logic [2:0] rc;
    logic [7:0] row;
    logic [7:0] col;
    logic       fd;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [7:0] pat(input int r);
    return 8'(8'h11 * (r + 1));
  endfunction

  function automatic logic [7:0] sel(input int r);
    logic [7:0] o;
    o = 8'd1 << r;
    return ~o;
  endfunction

  // The output seen after edge k shows the decode of cnt=(k-1)%20. Full brightness is assumed.
  function automatic bit on_full(input int kk);
    int c;
    c = (kk - 1) % 20;
    return (c >= 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (k=%0d)", name, act, exp, k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) k++;
    else k = 0;
    @(negedge clk);
  endtask

  task automatic measure_pwm(input logic [2:0] b, input int exp_on, input int exp_ff);
    int on_cnt;
    int ff_cnt;
    int viol;
    logic [2:0] prev_rc;
    brightness = b;
    repeat (20) step();
    while (k % 20 != 0) step();
    on_cnt = 0;
    ff_cnt = 0;
    viol = 0;
    prev_rc = row_count;
    repeat (20) begin
      step();
      if (dot_row !== 8'hFF) on_cnt++;
      else ff_cnt++;
      if (b != 3'd7 && row_count != prev_rc && dot_row !== 8'hFF) viol++;
      prev_rc = row_count;
    end
    chk($sformatf("pwm_on_b%0d", b), on_cnt, exp_on);
    chk($sformatf("pwm_ff_b%0d", b), ff_cnt, exp_ff);
    if (b != 3'd7) chk($sformatf("row_change_blank_b%0d", b), viol, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_cnt, fd_bad, ff_cnt, runs, bad_runs, multi, cur_len, r, nb, guard;
    logic prev_ff;

    n_vec = 0;
    n_err = 0;
    k = 0;
    reset_n = 1'b0;
    display_en = 1'b1;
    brightness = 3'd7;
    ovr = 1'b0;
    ovr_val = 8'h00;

    // 1: reset state
    @(negedge clk);
    repeat (3) step();
    chk("reset_row_count", row_count, 3'd0);
    chk("reset_dot_row", dot_row, 8'hFF);
    chk("reset_dot_col_out", dot_col_out, 8'h00);
    chk("reset_frame_done", frame_done, 1'b0);

    // 2: scan order, hand-computed at full brightness
    tbl[0]  = '{k:1,   rc:3'd0, row:8'hFF, col:8'h00, fd:1'b0};
    tbl[1]  = '{k:4,   rc:3'd0, row:8'hFF, col:8'h00, fd:1'b0};
    tbl[2]  = '{k:5,   rc:3'd0, row:8'hFE, col:8'h11, fd:1'b0};
    tbl[3]  = '{k:20,  rc:3'd1, row:8'hFE, col:8'h11, fd:1'b0};
    tbl[4]  = '{k:21,  rc:3'd1, row:8'hFF, col:8'h00, fd:1'b0};
    tbl[5]  = '{k:25,  rc:3'd1, row:8'hFD, col:8'h22, fd:1'b0};
    tbl[6]  = '{k:65,  rc:3'd3, row:8'hF7, col:8'h44, fd:1'b0};
    tbl[7]  = '{k:159, rc:3'd7, row:8'h7F, col:8'h88, fd:1'b0};
    tbl[8]  = '{k:160, rc:3'd0, row:8'h7F, col:8'h88, fd:1'b1};
    tbl[9]  = '{k:161, rc:3'd0, row:8'hFF, col:8'h00, fd:1'b0};
    tbl[10] = '{k:165, rc:3'd0, row:8'hFE, col:8'h11, fd:1'b0};

    reset_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      while (k < tbl[i].k) step();
      chk($sformatf("vec%0d_row_count", i), row_count, tbl[i].rc);
      chk($sformatf("vec%0d_dot_row", i), dot_row, tbl[i].row);
      chk($sformatf("vec%0d_dot_col_out", i), dot_col_out, tbl[i].col);
      chk($sformatf("vec%0d_frame_done", i), frame_done, tbl[i].fd);
    end

    // frame_done: exactly one pulse per 160 clocks, on the 7->0 edge
    fd_cnt = 0;
    fd_bad = 0;
    repeat (160) begin
      step();
      if (frame_done) begin
        fd_cnt++;
        if (k % 160 != 0) fd_bad++;
      end
    end
    chk("frame_done_count", fd_cnt, 1);
    chk("frame_done_position", fd_bad, 0);

    // 3: blanking over one frame at full brightness. The output after k=325 is ON.
    ff_cnt = 0;
    runs = 0;
    bad_runs = 0;
    multi = 0;
    cur_len = 0;
    prev_ff = (dot_row === 8'hFF);
    repeat (160) begin
      step();
      if ($countones(~dot_row) > 1) multi++;
      if (dot_row === 8'hFF) begin
        ff_cnt++;
        if (!prev_ff) begin
          runs++;
          cur_len = 0;
        end
        cur_len++;
        prev_ff = 1'b1;
      end else begin
        if (prev_ff && runs > 0 && cur_len != 4) bad_runs++;
        prev_ff = 1'b0;
      end
    end
    chk("blank_cycles_per_frame", ff_cnt, 32);
    chk("blank_runs_per_frame", runs, 8);
    chk("blank_run_not_4", bad_runs, 0);
    chk("multi_row_active", multi, 0);

    // 4: PWM
    measure_pwm(3'd0, 2, 18);
    measure_pwm(3'd3, 8, 12);
    measure_pwm(3'd7, 16, 4);

    // 5: sample point. Change dot_col at cnt=10 of a row.
    while (k % 20 != 10) step();
    r = (k / 20) % 8;
    ovr_val = 8'hA5;
    ovr = 1'b1;
    while (k % 20 != 16) step();
    chk("sample_same_row_col", dot_col_out, pat(r));
    chk("sample_same_row_sel", dot_row, sel(r));
    step();
    while (k % 20 != 7) step();
    chk("sample_next_row_col", dot_col_out, 8'hA5);
    chk("sample_next_row_sel", dot_row, sel((r + 1) % 8));
    ovr = 1'b0;

    // 6a: display_en low for 30 cycles mid-row
    while (k % 20 != 8) step();
    display_en = 1'b0;
    nb = 0;
    repeat (30) begin
      step();
      if (dot_row !== 8'hFF || dot_col_out !== 8'h00) nb++;
    end
    chk("disabled_outputs_blank", nb, 0);
    chk("disabled_row_advances", row_count, 3'((k / 20) % 8));
    display_en = 1'b1;
    guard = 0;
    step();
    while (!on_full(k) && guard < 40) begin
      step();
      guard++;
    end
    chk("reenable_timeout", guard < 40, 1'b1);
    chk("reenable_dot_row", dot_row, sel(((k - 1) / 20) % 8));
    chk("reenable_dot_col_out", dot_col_out, pat(((k - 1) / 20) % 8));

    // 6b: reset at cnt=12 of row 5
    while (k % 160 != 112) step();
    chk("pre_reset_row5", row_count, 3'd5);
    reset_n = 1'b0;
    step();
    chk("midrow_reset_row_count", row_count, 3'd0);
    chk("midrow_reset_dot_row", dot_row, 8'hFF);
    chk("midrow_reset_dot_col_out", dot_col_out, 8'h00);
    chk("midrow_reset_frame_done", frame_done, 1'b0);
    reset_n = 1'b1;
    step();
    chk("restart_k1_row_count", row_count, 3'd0);
    chk("restart_k1_dot_row", dot_row, 8'hFF);
    while (k < 5) step();
    chk("restart_k5_dot_row", dot_row, 8'hFE);
    chk("restart_k5_dot_col_out", dot_col_out, 8'h11);
    while (k < 21) step();
    chk("restart_k21_row_count", row_count, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
